data_mem: RTL and testbench
===========================

# data_mem

Data-memory responder that sits on the far side of the pipeline's memory port. It accepts the Mem stage's read address, write address, write data and write enable, and returns read data one cycle later, in time for the Wr stage to capture it. It holds a word-addressed synchronous RAM and a small memory-mapped I/O region: an LED/output register and a free-running cycle counter.

## Interface
- ADDR_W, 10, word-address bits of the RAM; depth is 2^ADDR_W 32-bit words.
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- rdaddr  input  32  Byte read address from the Mem stage; valid every cycle.
- maddr  input  32  Byte write address.
- wdata  input  32  Write data.
- wme  input  1  Write enable; a write is performed at the rising edge where wme=1.
- memdata  output  32  Registered read data for the rdaddr presented in the previous cycle.
- led  output  32  Current value of the LED register.

## Operation
- Address decode (applies to both rdaddr and maddr):
  - IO region: addr[31:28] == 4'hF.
  - RAM region: everything else. Word index = addr[ADDR_W+1:2].
  - addr[1:0] is ignored; no byte lanes, so all accesses are whole-word.
  - In the RAM region, bits above ADDR_W+1 are ignored, so addresses alias modulo 2^(ADDR_W+2) bytes.
- IO registers, selected by addr[3:2] within the IO region:
  - 0 = LED: read/write.
  - 1 = CNT: reading returns the counter; any write clears it to 0 (wdata is ignored).
  - 2 and 3 = reserved: reads return 0, writes have no effect.
- RAM write: on each rising edge with wme=1 and maddr in the RAM region, mem[index(maddr)] <= wdata.
- LED write: on each rising edge with wme=1 and maddr decoding to LED, led <= wdata.
- Read: on every rising edge, memdata <= value at rdaddr. There is no read enable; a read happens every cycle.
- Read/write collision in the same cycle:
  - If wme=1 and rdaddr and maddr resolve to the same RAM word, memdata returns wdata (write-first bypass).
  - The same bypass applies to LED: memdata returns wdata.
  - CNT is the exception: a read in the same cycle as a clearing write returns the counter value before the clear.
- Counter: a 32-bit register that increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0. A clearing write takes priority over the increment, so the value after that edge is 0.
- Reset (asynchronous, applies immediately):
  - memdata = 0, led = 0, CNT = 0.
  - RAM contents are not reset and are undefined until written.
  - A write or read in flight when reset asserts is discarded.
  - After reset deasserts, the first edge behaves normally.

## Timing
- Read latency is exactly 1 cycle: rdaddr sampled at edge N appears on memdata immediately after edge N, stable until edge N+1.
- A write takes effect at the edge where wme=1. A read at the next cycle sees the new value; the same-cycle read also sees it, via the bypass.
- CNT read at edge N returns the number of edges since reset (or since the last clear), counted up to but not including edge N.
- led changes only at an edge with a LED write, or on reset.
- There are no stall or handshake signals; the block accepts one read and one write every cycle.

## Test plan
- Reset then read: assert rst mid-cycle -> memdata=0 and led=0 immediately. Release rst, read 0xF000_0004 at the first edge -> memdata=0. Read it again 5 edges later -> memdata=5.
- RAM write/read: write 0xDEAD_BEEF to 0x0000_0010. Next cycle read 0x0000_0010 -> memdata=0xDEAD_BEEF. Read 0x0000_0013 -> same value (low bits ignored). Read 0x0000_1010 -> same value with ADDR_W=10 (aliasing).
- Collision bypass: in one cycle write 0x1234_5678 to 0x20 and read 0x20 -> memdata=0x1234_5678 after that edge. A read of 0x24 in the same cycle returns the old contents of 0x24.
- LED: write 0x0000_00A5 to 0xF000_0000 -> led=0xA5 after the edge. A same-cycle read of 0xF000_0000 -> memdata=0xA5. A write to 0xF000_0008 leaves led unchanged, and reading 0xF000_0008 returns 0.
- Counter clear and wrap:
  - Force CNT to 0xFFFF_FFFF (by running or by a bench preload); the next read shows 0 after the wrap.
  - Write to 0xF000_0004 while reading it: memdata = pre-clear value; a read one cycle later = 0; a read one cycle after that = 1.
- Reset mid-write: assert rst during a cycle with wme=1 to 0xF000_0000 and wdata=0xFF -> led stays 0 after rst releases.

Source files
------------

// File: rtl/data_mem_if.sv
// Memory-port bundle between the pipeline's Mem stage (master) and the data
// memory responder (slave).
interface data_mem_if;
    logic [31:0] rdaddr;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic        wme;
    logic [31:0] memdata;
    logic [31:0] led;

    modport master (output rdaddr, maddr, wdata, wme, input memdata, led);
    modport slave  (input rdaddr, maddr, wdata, wme, output memdata, led);
endinterface

// File: rtl/data_mem.sv
// Word-addressed data RAM plus a small IO region (LED register, cycle counter)
// answering one read and one write every cycle with a registered read port.
module data_mem #(
    parameter int ADDR_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus
);
    localparam logic [1:0] IO_LED = 2'd0;
    localparam logic [1:0] IO_CNT = 2'd1;

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] led_q;
    logic [31:0] cnt;
    logic [31:0] rd_next;

    logic              rd_io, wr_io;
    logic [ADDR_W-1:0] rd_idx, wr_idx;
    logic              ram_we, led_we, cnt_clr;

    assign rd_io  = bus.rdaddr[31:28] == 4'hF;
    assign wr_io  = bus.maddr[31:28] == 4'hF;
    assign rd_idx = bus.rdaddr[ADDR_W+1:2];
    assign wr_idx = bus.maddr[ADDR_W+1:2];

    assign ram_we  = bus.wme && !wr_io;
    assign led_we  = bus.wme && wr_io && bus.maddr[3:2] == IO_LED;
    assign cnt_clr = bus.wme && wr_io && bus.maddr[3:2] == IO_CNT;

    // Bits that play no part in decoding: RAM aliasing and ignored byte offset.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.rdaddr[27:ADDR_W+2], bus.rdaddr[1:0],
                                bus.maddr[27:ADDR_W+2], bus.maddr[1:0]};

    // Write-first bypass for RAM and LED; CNT deliberately returns the pre-clear value.
    always_comb begin
        rd_next = 32'd0;
        if (rd_io) begin
            case (bus.rdaddr[3:2])
                IO_LED:  rd_next = led_we ? bus.wdata : led_q;
                IO_CNT:  rd_next = cnt;
                default: rd_next = 32'd0;
            endcase
        end else if (ram_we && rd_idx == wr_idx) begin
            rd_next = bus.wdata;
        end else begin
            rd_next = mem[rd_idx];
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; the rst gate only
    // discards a write that coincides with reset.
    always_ff @(posedge clk) begin
        if (!rst && ram_we)
            mem[wr_idx] <= bus.wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.memdata <= 32'd0;
            led_q       <= 32'd0;
            cnt         <= 32'd0;
        end else begin
            bus.memdata <= rd_next;
            if (led_we)
                led_q <= bus.wdata;
            cnt <= cnt_clr ? 32'd0 : cnt + 32'd1;
        end
    end

    assign bus.led = led_q;
endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: reset, RAM access and aliasing, collision bypass,
// LED register, counter wrap and clear, reset during a write.
module tb_data_mem;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    data_mem_if bus ();

    data_mem #(.ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] rd, input logic [31:0] ma,
                         input logic [31:0] wd, input logic we);
        @(negedge clk);
        bus.rdaddr = rd;
        bus.maddr  = ma;
        bus.wdata  = wd;
        bus.wme    = we;
    endtask

    task automatic test_reset();
        edge_sample();
        edge_sample();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.memdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_memdata: got %h want %h", bus.memdata, 32'd0);
        end
        checks++;
        if (bus.led !== 32'd0) begin
            errors++;
            $display("FAIL reset_led: got %h want %h", bus.led, 32'd0);
        end
        edge_sample();
        @(negedge clk);
        rst = 1'b0;
        bus.rdaddr = 32'hF000_0004;
        edge_sample();
        checks++;
        if (bus.memdata !== 32'd0) begin
            errors++;
            $display("FAIL cnt_first_edge: got %h want %h", bus.memdata, 32'd0);
        end
        repeat (5) edge_sample();
        checks++;
        if (bus.memdata !== 32'd5) begin
            errors++;
            $display("FAIL cnt_after_5: got %h want %h", bus.memdata, 32'd5);
        end
    endtask

    task automatic test_ram();
        logic [31:0] rd_vec [3];
        rd_vec[0] = 32'h0000_0010;
        rd_vec[1] = 32'h0000_0013;
        rd_vec[2] = 32'h0000_1010;
        drive(32'h0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        edge_sample();
        for (int i = 0; i < 3; i++) begin
            drive(rd_vec[i], 32'h0, 32'h0, 1'b0);
            edge_sample();
            checks++;
            if (bus.memdata !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL ram_read[%0d] addr %h: got %h want %h",
                         i, rd_vec[i], bus.memdata, 32'hDEAD_BEEF);
            end
        end
    endtask

    task automatic test_bypass();
        drive(32'h0, 32'h0000_0024, 32'hCAFE_0024, 1'b1);
        edge_sample();
        drive(32'h0000_0020, 32'h0000_0020, 32'h1234_5678, 1'b1);
        edge_sample();
        checks++;
        if (bus.memdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL bypass_same: got %h want %h", bus.memdata, 32'h1234_5678);
        end
        drive(32'h0000_0024, 32'h0000_0020, 32'h1111_1111, 1'b1);
        edge_sample();
        checks++;
        if (bus.memdata !== 32'hCAFE_0024) begin
            errors++;
            $display("FAIL bypass_other: got %h want %h", bus.memdata, 32'hCAFE_0024);
        end
        drive(32'h0000_0020, 32'h0, 32'h0, 1'b0);
        edge_sample();
        checks++;
        if (bus.memdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL bypass_written: got %h want %h", bus.memdata, 32'h1111_1111);
        end
    endtask

    task automatic test_led();
        drive(32'hF000_0000, 32'hF000_0000, 32'h0000_00A5, 1'b1);
        edge_sample();
        checks++;
        if (bus.led !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL led_write: got %h want %h", bus.led, 32'h0000_00A5);
        end
        checks++;
        if (bus.memdata !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL led_bypass: got %h want %h", bus.memdata, 32'h0000_00A5);
        end
        drive(32'hF000_0008, 32'hF000_0008, 32'h5A5A_5A5A, 1'b1);
        edge_sample();
        checks++;
        if (bus.led !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL led_reserved_write: got %h want %h", bus.led, 32'h0000_00A5);
        end
        checks++;
        if (bus.memdata !== 32'd0) begin
            errors++;
            $display("FAIL reserved_read: got %h want %h", bus.memdata, 32'd0);
        end
        drive(32'hF000_0000, 32'hF000_000C, 32'h7777_7777, 1'b1);
        edge_sample();
        checks++;
        if (bus.memdata !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL led_read: got %h want %h", bus.memdata, 32'h0000_00A5);
        end
    endtask

    task automatic test_counter_wrap();
        drive(32'hF000_0004, 32'h0, 32'h0, 1'b0);
        force dut.cnt = 32'hFFFF_FFFF;
        #1 release dut.cnt;
        edge_sample();
        checks++;
        if (bus.memdata !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL cnt_max: got %h want %h", bus.memdata, 32'hFFFF_FFFF);
        end
        edge_sample();
        checks++;
        if (bus.memdata !== 32'd0) begin
            errors++;
            $display("FAIL cnt_wrap: got %h want %h", bus.memdata, 32'd0);
        end
    endtask

    task automatic test_counter_clear();
        logic [31:0] exp [3];
        exp[0] = 32'd2;
        exp[1] = 32'd0;
        exp[2] = 32'd1;
        drive(32'h0000_0010, 32'hF000_0004, 32'h0000_FFFF, 1'b1);
        edge_sample();
        drive(32'h0000_0010, 32'h0, 32'h0, 1'b0);
        edge_sample();
        edge_sample();
        drive(32'hF000_0004, 32'hF000_0004, 32'h0000_FFFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            checks++;
            if (bus.memdata !== exp[i]) begin
                errors++;
                $display("FAIL cnt_clear[%0d]: got %h want %h", i, bus.memdata, exp[i]);
            end
            drive(32'hF000_0004, 32'h0, 32'h0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_write();
        drive(32'hF000_0000, 32'hF000_0000, 32'h0000_00FF, 1'b1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.led !== 32'd0) begin
            errors++;
            $display("FAIL midwrite_led_in_reset: got %h want %h", bus.led, 32'd0);
        end
        edge_sample();
        @(negedge clk);
        bus.wme = 1'b0;
        rst = 1'b0;
        edge_sample();
        checks++;
        if (bus.led !== 32'd0) begin
            errors++;
            $display("FAIL midwrite_led_after: got %h want %h", bus.led, 32'd0);
        end
        checks++;
        if (bus.memdata !== 32'd0) begin
            errors++;
            $display("FAIL midwrite_memdata: got %h want %h", bus.memdata, 32'd0);
        end
    endtask

    initial begin
        bus.rdaddr = 32'h0;
        bus.maddr  = 32'h0;
        bus.wdata  = 32'h0;
        bus.wme    = 1'b0;
        test_reset();
        test_ram();
        test_bypass();
        test_led();
        test_counter_wrap();
        test_counter_clear();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
